// File: rtl/node_input_sequencer.sv
// node_input_sequencer: buffers Q11.4 value/weight pairs and streams them into a MAC, then captures its sum.
// Define NODE_SEQ_RELU_EN to pass the captured sum through ReLU.
module node_input_sequencer #(
  parameter int DEPTH   = 10,
  parameter int ADDR_W  = 4,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_value,
  input  logic [15:0]       wr_weight,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic [15:0]       mac_value,
  output logic [15:0]       mac_weight,
  output logic              mac_valid,
  output logic              mac_clear,
  input  logic [15:0]       mac_out,
  output logic              busy,
  output logic [15:0]       result,
  output logic              result_valid
);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [31:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx, idx_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [ADDR_W:0] len_q;
  logic [15:0] cap;
  always_ff @(posedge clk)
    if (wr_en && !busy && {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH)) mem[wr_addr] <= {wr_value, wr_weight};
  always_comb begin
    nxt = state;
    idx_n = idx;
    dcnt_n = dcnt;
    case (state)
      IDLE: if (start && len != '0) begin
        nxt = CLEAR;
        idx_n = '0;
      end
      CLEAR: begin
        nxt = STREAM;
        idx_n = '0;
      end
      STREAM: if ({1'b0, idx} == len_q - 1'b1) begin
        nxt = DRAIN;
        idx_n = '0;
        dcnt_n = '0;
      end else idx_n = idx + 1'b1;
      DRAIN: if (dcnt == DW'(MAC_LAT - 1)) nxt = DONE;
        else dcnt_n = dcnt + 1'b1;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
`ifdef NODE_SEQ_RELU_EN
  assign cap = mac_out[15] ? 16'h0000 : mac_out;
`else
  assign cap = mac_out;
`endif
  // Outputs are registered from the next state so each one lines up with the state it belongs to.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      dcnt <= '0;
      len_q <= '0;
      mac_value <= '0;
      mac_weight <= '0;
      mac_valid <= 1'b0;
      mac_clear <= 1'b0;
      busy <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      state <= nxt;
      idx <= idx_n;
      dcnt <= dcnt_n;
      if (state == IDLE && nxt == CLEAR) len_q <= (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;
      mac_value <= (nxt == STREAM) ? mem[idx_n][31:16] : '0;
      mac_weight <= (nxt == STREAM) ? mem[idx_n][15:0] : '0;
      mac_valid <= nxt == STREAM;
      mac_clear <= nxt == CLEAR;
      busy <= nxt != IDLE;
      if (state == DRAIN && nxt == DONE) result <= cap;
      result_valid <= nxt == DONE;
    end
endmodule
